i2c_codec_target: RTL and testbench
===================================

# i2c_codec_target

I2C write-only target that models the SSM2603 audio codec's control port on the same two-wire bus the codec configuration master drives. It receives 3-byte frames: device byte, then a 16-bit word split as a 7-bit register address and 9-bit data. It ACKs frames addressed to it and commits each word into an internal register file. Used as the bus-side responder in simulation and as a drop-in stand-in when the board has no codec fitted.

## Interface
- DEV_ADDR, 7'h1A: 7-bit target address; write byte 8'h34.
- REG_COUNT, 16: register file depth; valid register addresses are 0..REG_COUNT-1.
- clk  in  1  system clock; SCL and SDA are sampled on it.
- reset  in  1  synchronous, active-high.
- i2c_sclk  in  1  bus clock from the master; asynchronous.
- i2c_sdat  inout  1  open-drain data; driven only 1'b0 or 1'bz.
- wr_valid  out  1  one-cycle pulse when a frame commits.
- wr_addr  out  7  register address of the committed frame.
- wr_data  out  9  data of the committed frame.
- wr_err  out  1  sticky flag; set when a commit has wr_addr ≥ REG_COUNT.
- rd_addr  in  4  combinational read port address.
- rd_data  out  9  reg[rd_addr].
- busy  out  1  high from START until STOP.

## Operation
- Synchronization:
  - SCL and SDA each pass through a 2-flop synchronizer, then one history register.
  - Events are decoded on synchronized values:
    - SCL rise and SCL fall.
    - START: SDA falls while SCL is high.
    - STOP: SDA rises while SCL is high.
- Data bits are sampled on SCL rise, MSB first.
- The ACK drive (SDA low) is asserted on the SCL fall after the 8th rise and released on the next SCL fall.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits. On the 8th bit, byte == {DEV_ADDR,1'b0} → ADDR_ACK; anything else, including a read bit → IGNORE with no ACK.
  - ADDR_ACK → BYTE1.
  - BYTE1: shifts 8 bits → ACK1.
  - ACK1 → BYTE2.
  - BYTE2: shifts 8 bits → ACK2.
  - ACK2 → DONE.
  - DONE: any further byte is not ACKed → IGNORE.
  - IGNORE: SDA released; waits for START or STOP.
- START in any state, including a repeated START: bit counter cleared, go to ADDR, SDA released. STOP in any state: go to IDLE, SDA released.
- Frame packing:
  - wr_addr = byte1[7:1].
  - wr_data = {byte1[0], byte2}.
- Commit:
  - wr_valid pulses in the same cycle the ACK2 drive asserts.
  - wr_addr and wr_data are held until the next commit.
  - If wr_addr < REG_COUNT, reg[wr_addr] ← wr_data. Otherwise the file is untouched, wr_err is set, and the frame is still ACKed.
- A STOP or START before the ACK2 drive aborts the frame: no commit, registers unchanged.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset values:
  - SDA released (z); state IDLE.
  - wr_valid 0, wr_addr 0, wr_data 0, wr_err 0, busy 0.
  - All registers 9'h000.
- Latency from a bus edge to the internal event is 3 clk cycles (2 sync + 1 edge detect).
- SDA drive changes 1 cycle after the decoded SCL fall.
- Bus requirement: SCL high and low phases each ≥ 8 clk; SDA setup to SCL rise ≥ 4 clk.
- The target's SDA changes only while SCL is low, so it never generates a false START/STOP.
- Reset mid-frame: SDA released the next cycle, no commit. The master sees a NACK or a glitch-free release.
- rd_data is combinational from the register file. A write and a read to the same address in the same cycle return the old value.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_tgt_state_t`.
  - `SSM2603_I2C_ADDR` = 7'h1A.
  - `I2C_WRITE_BYTE` = 8'h34.
- Sub-module `i2c_bus_sync`:
  - synchronizers plus edge decode.
  - outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
  - reusable by future bus monitors.
- Register file stays inline.

## Test plan
- Bytes 0x34, 0x0C, 0x10 then STOP → 3 ACKs; wr_valid once with wr_addr=0x06, wr_data=0x010; rd_data at rd_addr=6 reads 0x010.
- Byte 0x36 → no ACK on the 9th clock; later bytes ignored; no wr_valid; busy drops on STOP.
- Byte 0x35 (read) → NACK, no commit, SDA never driven.
- 0x34, 0x08, then STOP → no commit; reg[4] stays 0x000. A following full 0x34 0x08 0xD4 commits reg[4]=0x0D4.
- Full 11-word configuration sequence → registers match, e.g.:
  - reg[0]=0x017, reg[2]=0x079, reg[4]=0x0D4, reg[5]=0x004, reg[6]=0x000.
  - reg[7]=0x001, reg[8]=0x034, reg[9]=0x001.
  - 11 wr_valid pulses.
- Reset asserted at the 5th bit of byte2 → SDA z within 1 cycle, no commit. A frame 0x34 0x1E 0x00 to address 0x0F with REG_COUNT=8 → ACKed, wr_err=1, file unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C codec-control target and related bus logic.
//   i2c_tgt_state_t  : target frame-tracking state
//   SSM2603_I2C_ADDR : 7-bit bus address of the SSM2603 control port
//   I2C_WRITE_BYTE   : address byte for a write to that port ({addr, 1'b0})
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_DONE,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic [6:0] SSM2603_I2C_ADDR = 7'h1A;
    localparam logic [7:0] I2C_WRITE_BYTE   = 8'h34;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings asynchronous SCL/SDA into the clk domain and decodes bus events.
//   clk, reset  : system clock, synchronous active-high reset
//   scl, sda    : raw bus lines
//   scl_rise    : one-cycle pulse on a synchronized SCL rising edge
//   scl_fall    : one-cycle pulse on a synchronized SCL falling edge
//   start_det   : SDA fell while SCL high
//   stop_det    : SDA rose while SCL high
//   sda_s       : synchronized SDA aligned with the event pulses
// Events appear 3 clk after the bus edge (2 sync flops + registered decode).
// ---------------------------------------------------------------------------
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_m, scl_s, scl_h;
    logic sda_m, sda_y, sda_h;

    // Idle bus is pulled high, so reset the chain to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_m     <= 1'b1;
            scl_s     <= 1'b1;
            scl_h     <= 1'b1;
            sda_m     <= 1'b1;
            sda_y     <= 1'b1;
            sda_h     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_m     <= scl;
            scl_s     <= scl_m;
            scl_h     <= scl_s;
            sda_m     <= sda;
            sda_y     <= sda_m;
            sda_h     <= sda_y;
            scl_rise  <= scl_s & ~scl_h;
            scl_fall  <= ~scl_s & scl_h;
            start_det <= scl_s & scl_h & ~sda_y & sda_h;
            stop_det  <= scl_s & scl_h & sda_y & ~sda_h;
        end
    end

    // sda_h holds the SDA value seen in the cycle the event was decoded.
    assign sda_s = sda_h;

endmodule

// File: rtl/i2c_codec_target.sv
// ---------------------------------------------------------------------------
// i2c_codec_target
// Write-only I2C target standing in for the SSM2603 control port. Accepts
// frames of device byte + 16-bit word {reg_addr[6:0], data[8:0]}, ACKs
// frames addressed to DEV_ADDR and commits each word into a register file.
//   clk, reset : system clock, synchronous active-high reset
//   i2c_sclk   : bus clock from the master (asynchronous)
//   i2c_sdat   : open-drain data, driven only 0 or z
//   wr_valid   : one-cycle pulse when a frame commits
//   wr_addr    : register address of the last committed frame
//   wr_data    : data of the last committed frame
//   wr_err     : sticky, set when a commit addressed reg >= REG_COUNT
//   rd_addr    : combinational read port address
//   rd_data    : register file contents at rd_addr
//   busy       : high from START until STOP
// ---------------------------------------------------------------------------
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = SSM2603_I2C_ADDR,
    parameter int unsigned REG_COUNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       wr_err,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (i2c_sclk),
        .sda       (i2c_sdat),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] byte1;
    logic       sda_oe;
    logic [8:0] regs [REG_COUNT];

    logic [7:0] next_byte;
    logic [6:0] commit_addr;
    logic [8:0] commit_data;
    logic       commit_in_range;

    assign next_byte   = {shreg[6:0], sda_s};
    // Shifting stops after byte2 is complete, so shreg still holds byte2 here.
    assign commit_addr = byte1[7:1];
    assign commit_data = {byte1[0], shreg};
    assign commit_in_range = ({25'd0, commit_addr} < REG_COUNT);

    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            byte1    <= 8'h00;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 7'd0;
            wr_data  <= 9'h000;
            wr_err   <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= 9'h000;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                // Also covers repeated START: any frame in progress is dropped.
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_BYTE1, ST_BYTE2, ST_DONE: begin
                        if (scl_rise) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    ST_ADDR: state <= (next_byte == {DEV_ADDR, 1'b0})
                                                      ? ST_ADDR_ACK : ST_IGNORE;
                                    ST_BYTE1: begin
                                        byte1 <= next_byte;
                                        state <= ST_ACK1;
                                    end
                                    ST_BYTE2: state <= ST_ACK2;
                                    default:  state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    // First SCL fall after the 8th rise drives ACK, the next releases it.
                    ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                if (state == ST_ACK2) begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= commit_addr;
                                    wr_data  <= commit_data;
                                    if (commit_in_range)
                                        regs[commit_addr[AW-1:0]] <= commit_data;
                                    else
                                        wr_err <= 1'b1;
                                end
                            end else begin
                                sda_oe <= 1'b0;
                                case (state)
                                    ST_ADDR_ACK: state <= ST_BYTE1;
                                    ST_ACK1:     state <= ST_BYTE2;
                                    default:     state <= ST_DONE;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reads see the pre-write value when a commit lands in the same cycle.
    assign rd_data = ({28'd0, rd_addr} < REG_COUNT) ? regs[rd_addr[AW-1:0]] : 9'h000;

endmodule

// File: tb/tb_i2c_codec_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_codec_target
// Drives I2C write frames into two targets sharing one bus (REG_COUNT 16 and
// 8). Expected commits are queued when a frame is issued and popped by an
// independent monitor on every wr_valid; ACKs and register contents are
// compared against a plain array model of the codec register file.
// ---------------------------------------------------------------------------
module tb_i2c_codec_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] rd_addr = 4'd0;

    wire sda_bus;
    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    logic       wr_valid, wr_err, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic       wr_valid_8, wr_err_8, busy_8;
    logic [6:0] wr_addr_8;
    logic [8:0] wr_data_8, rd_data_8;

    i2c_codec_target #(.DEV_ADDR(7'h1A), .REG_COUNT(16)) dut (
        .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda_bus),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    i2c_codec_target #(.DEV_ADDR(7'h1A), .REG_COUNT(8)) dut8 (
        .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda_bus),
        .wr_valid(wr_valid_8), .wr_addr(wr_addr_8), .wr_data(wr_data_8),
        .wr_err(wr_err_8), .rd_addr(rd_addr), .rd_data(rd_data_8), .busy(busy_8)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] a;
        logic [8:0] d;
    } exp_t;
    exp_t expq[$];

    logic [8:0] m16 [16];
    logic [8:0] m8  [8];
    logic       e16, e8;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m16[i] = 9'h000;
        for (int i = 0; i < 8; i++) m8[i] = 9'h000;
        e16 = 1'b0;
        e8  = 1'b0;
    endtask

    task automatic bus_start();
        m_low = 1'b0; wclk(6);
        scl = 1'b1;   wclk(10);
        m_low = 1'b1; wclk(10);
        scl = 1'b0;   wclk(4);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wclk(6);
        scl = 1'b1;   wclk(10);
        m_low = 1'b0; wclk(10);
    endtask

    // rst_bit: bit index (7..0) at which to pulse reset, or -1 for none.
    task automatic write_byte(input logic [7:0] b, input int rst_bit, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i];
            wclk(6);
            if (i == rst_bit) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk("reset_sda_released", int'(sda_bus), 1);
                chk("reset_busy", int'(busy), 0);
                reset = 1'b0;
            end
            scl = 1'b1; wclk(10);
            scl = 1'b0; wclk(4);
        end
        m_low = 1'b0; wclk(6);
        scl = 1'b1; wclk(5); #1;
        acked = (sda_bus == 1'b0);
        wclk(5);
        scl = 1'b0; wclk(4);
    endtask

    task automatic send_frame(input logic [7:0] dev, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int nbytes, input int rst_bit);
        logic [7:0] by [4];
        logic       ack;
        logic       aborted;
        logic [6:0] a;
        logic [8:0] d;
        exp_t       e;
        by[0] = dev; by[1] = b1; by[2] = b2; by[3] = b3;
        aborted = 1'b0;
        a = b1[7:1];
        d = {b1[0], b2};
        if (dev == 8'h34 && nbytes >= 3 && rst_bit < 0) begin
            e.a = a; e.d = d;
            expq.push_back(e);
            if (a < 7'd16) m16[a[3:0]] = d; else e16 = 1'b1;
            if (a < 7'd8)  m8[a[2:0]]  = d; else e8  = 1'b1;
        end
        bus_start();
        chk("busy_after_start", int'(busy), 1);
        for (int k = 0; k < nbytes; k++) begin
            write_byte(by[k], (k == 2) ? rst_bit : -1, ack);
            if (k == 2 && rst_bit >= 0) begin
                aborted = 1'b1;
                model_clear();
            end
            chk($sformatf("ack_byte%0d_dev%02h", k, dev), int'(ack),
                int'(dev == 8'h34 && k < 3 && !aborted));
        end
        bus_stop();
        wclk(4);
        chk("busy_after_stop", int'(busy), 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("%s_reg16[%0d]", tag, i), int'(rd_data), int'(m16[i]));
            chk($sformatf("%s_reg8[%0d]", tag, i), int'(rd_data_8),
                (i < 8) ? int'(m8[i]) : 0);
        end
        chk({tag, "_wr_err16"}, int'(wr_err), int'(e16));
        chk({tag, "_wr_err8"}, int'(wr_err_8), int'(e8));
    endtask

    // Commit monitor: independent of the stimulus process.
    always @(negedge clk) begin
        if (!reset && (wr_valid || wr_valid_8)) begin
            if (expq.size() == 0) begin
                chk("unexpected_commit", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("commit_both_targets", int'({wr_valid, wr_valid_8}), 3);
                chk("wr_addr", int'(wr_addr), int'(e.a));
                chk("wr_data", int'(wr_data), int'(e.d));
                chk("wr_addr8", int'(wr_addr_8), int'(e.a));
                chk("wr_data8", int'(wr_data_8), int'(e.d));
                chk("commit_with_ack_drive", int'(sda_bus), 0);
            end
        end
    end

    initial begin
        wclk(80000);
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] a;
        logic [8:0] d;
    } cfg_t;

    initial begin
        cfg_t cfg [11];
        cfg[0]  = '{7'h0F, 9'h000}; cfg[1]  = '{7'h00, 9'h017};
        cfg[2]  = '{7'h01, 9'h017}; cfg[3]  = '{7'h02, 9'h079};
        cfg[4]  = '{7'h03, 9'h079}; cfg[5]  = '{7'h04, 9'h0D4};
        cfg[6]  = '{7'h05, 9'h004}; cfg[7]  = '{7'h06, 9'h000};
        cfg[8]  = '{7'h07, 9'h001}; cfg[9]  = '{7'h08, 9'h034};
        cfg[10] = '{7'h09, 9'h001};

        model_clear();
        reset = 1'b1;
        wclk(5);
        reset = 1'b0;
        wclk(2); #1;
        chk("reset_wr_valid", int'(wr_valid), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sda", int'(sda_bus), 1);
        check_regs("reset");

        // Basic write: reg 6 <- 0x010
        send_frame(8'h34, 8'h0C, 8'h10, 8'h00, 3, -1);
        chk("hold_wr_addr", int'(wr_addr), 6);
        chk("hold_wr_data", int'(wr_data), 9'h010);
        rd_addr = 4'd6; #1;
        chk("rd6_after_write", int'(rd_data), 9'h010);

        // Wrong device address, read bit: both NACKed, nothing committed
        send_frame(8'h36, 8'h0C, 8'h55, 8'h00, 3, -1);
        send_frame(8'h35, 8'h0C, 8'h55, 8'h00, 3, -1);

        // Aborted frame then full frame to reg 4
        send_frame(8'h34, 8'h08, 8'h00, 8'h00, 2, -1);
        rd_addr = 4'd4; #1;
        chk("rd4_after_abort", int'(rd_data), 0);
        send_frame(8'h34, 8'h08, 8'hD4, 8'h00, 3, -1);

        // Codec configuration sequence
        for (int i = 0; i < 11; i++)
            send_frame(8'h34, {cfg[i].a, cfg[i].d[8]}, cfg[i].d[7:0], 8'h00, 3, -1);
        check_regs("config");

        // Randomized frames: mostly to this target, some to others, varying length
        for (int n = 0; n < 24; n++) begin
            logic [7:0] dev;
            logic [6:0] a;
            logic [8:0] d;
            dev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
            a   = 7'($urandom_range(0, 19));
            d   = 9'($urandom);
            send_frame(dev, {a, d[8]}, d[7:0], 8'($urandom), $urandom_range(1, 4), -1);
        end
        check_regs("random");

        // Reset during byte2 (5th bit): no commit, everything back to reset state
        send_frame(8'h34, 8'h0C, 8'hFF, 8'h00, 3, 3);
        check_regs("midreset");

        // Out-of-range register for the 8-deep target: ACKed, error flagged
        send_frame(8'h34, 8'h1E, 8'h00, 8'h00, 3, -1);
        check_regs("range");

        wclk(20);
        chk("commit_queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
